// File: rtl/covert_ook_tx.sv
// covert_ook_tx: transmit-side on-off-keyed modulator for the environment-mediated
// covert channel. Payload bytes enter through a valid/ready handshake into a small FIFO.
// Each byte is sent as one frame: PREAMBLE_BITS preamble bits, then 8 data bits MSB
// first, then GAP_CYCLES of silence. Each bit lasts BIT_CYCLES clocks.
//
// Optional feature: define COVERT_TX_MANCHESTER_EN for Manchester chips.
//   bit 1 -> high/low halves, bit 0 -> low/high halves.
// Without the macro the output is plain NRZ OOK.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   enable     in   global transmit enable (dropping it mid-frame aborts the frame)
//   tx_data    in   payload byte
//   tx_valid   in   tx_data valid
//   tx_ready   out  FIFO can accept a byte
//   antenna_en out  modulated antenna excitation enable
//   busy       out  FSM not idle
//   frame_done out  one-cycle pulse at the end of each frame's gap
//   overflow   out  sticky: tx_valid seen while tx_ready low
module covert_ook_tx #(
    parameter int unsigned BIT_CYCLES    = 1024,
    parameter logic [7:0]  PREAMBLE      = 8'hAA,
    parameter int unsigned PREAMBLE_BITS = 8,
    parameter int unsigned GAP_CYCLES    = 4096,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       antenna_en,
    output logic       busy,
    output logic       frame_done,
    output logic       overflow
);

`ifdef COVERT_TX_MANCHESTER_EN
    localparam bit Manchester = 1'b1;
`else
    localparam bit Manchester = 1'b0;
`endif

    localparam int unsigned BitW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned GapW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned CntW   = (BitW > GapW) ? BitW : GapW;
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CntW-1:0]   BitLast    = CntW'(BIT_CYCLES - 1);
    localparam logic [CntW-1:0]   GapLast    = CntW'(GAP_CYCLES - 1);
    localparam logic [CntW-1:0]   HalfCycles = CntW'(BIT_CYCLES / 2);
    localparam logic [2:0]        PreLast    = 3'(PREAMBLE_BITS - 1);
    localparam logic [CountW-1:0] Full       = CountW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StPre, StData, StGap} state_e;

    // ---------------------------------------------------------------- FIFO
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic [CountW-1:0] count;
    logic [CountW-1:0] count_d;
    logic              head_valid;
    logic              push;
    logic              pop;
    state_e            state;

    assign push = tx_valid && tx_ready;
    assign pop  = (state == StIdle) && enable && head_valid;

    always_comb begin
        count_d = count;
        unique case ({push, pop})
            2'b10:   count_d = count + 1'b1;
            2'b01:   count_d = count - 1'b1;
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            tx_ready   <= 1'b0;
            head_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_d;
            // Registered view of count: a pop while full cannot admit a push that cycle.
            tx_ready <= (count_d != Full);
            // FSM acts on FIFO status one cycle late: a push at edge t starts the frame at
            // t+2. Safe because the FIFO only drains from IDLE and every frame leaves IDLE
            // for at least two cycles, so this flag is fresh whenever it is consulted.
            head_valid <= (count != '0);
            if (tx_valid && !tx_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- modulator
    logic [CntW-1:0] cyc_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      pre_sr;
    logic [7:0]      data_sr;
    logic            cur_bit;

    assign cur_bit = (state == StPre) ? pre_sr[7] : data_sr[7];

    // Output level for a bit at a given cycle of its period; the second half inverts
    // under Manchester.
    function automatic logic chip(input logic b, input logic [CntW-1:0] cyc);
        return b ^ (Manchester && (cyc >= HalfCycles));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            pre_sr     <= '0;
            data_sr    <= '0;
            antenna_en <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (pop) begin
                        state      <= StPre;
                        busy       <= 1'b1;
                        pre_sr     <= PREAMBLE;
                        data_sr    <= mem[rd_ptr];
                        bit_cnt    <= '0;
                        cyc_cnt    <= '0;
                        antenna_en <= chip(PREAMBLE[7], '0);
                    end
                end
                StPre, StData: begin
                    if (!enable) begin
                        // Abort: drop the byte, still run a full gap.
                        state      <= StGap;
                        cyc_cnt    <= '0;
                        antenna_en <= 1'b0;
                    end else if (cyc_cnt != BitLast) begin
                        cyc_cnt    <= cyc_cnt + 1'b1;
                        antenna_en <= chip(cur_bit, cyc_cnt + 1'b1);
                    end else begin
                        cyc_cnt <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (state == StPre) begin
                            if (bit_cnt == PreLast) begin
                                state      <= StData;
                                bit_cnt    <= '0;
                                antenna_en <= chip(data_sr[7], '0);
                            end else begin
                                pre_sr     <= pre_sr << 1;
                                antenna_en <= chip(pre_sr[6], '0);
                            end
                        end else begin
                            if (bit_cnt == 3'd7) begin
                                state      <= StGap;
                                antenna_en <= 1'b0;
                            end else begin
                                data_sr    <= data_sr << 1;
                                antenna_en <= chip(data_sr[6], '0);
                            end
                        end
                    end
                end
                StGap: begin
                    if (cyc_cnt == GapLast) begin
                        state      <= StIdle;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        cyc_cnt    <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_covert_ook_tx.sv
// Directed bench for covert_ook_tx with BIT_CYCLES=4, GAP_CYCLES=8, PREAMBLE=8'hAA,
// PREAMBLE_BITS=8, FIFO_DEPTH=4. A frame is 72 busy cycles: 16 bits x 4 plus an 8-cycle gap.
module tb_covert_ook_tx;
    localparam int BC = 4;
    localparam int GC = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       antenna_en;
    logic       busy;
    logic       frame_done;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;

    covert_ook_tx #(
        .BIT_CYCLES   (BC),
        .PREAMBLE     (8'hAA),
        .PREAMBLE_BITS(8),
        .GAP_CYCLES   (GC),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .antenna_en(antenna_en),
        .busy      (busy),
        .frame_done(frame_done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected antenna level k cycles into a frame carrying 'data'.
    function automatic logic exp_chip(input logic [7:0] data, input int k);
        logic [15:0] seq;
        logic        v;
        seq = {8'hAA, data};
        v = seq[15 - k / BC];
`ifdef COVERT_TX_MANCHESTER_EN
        if ((k % BC) >= BC / 2) v = ~v;
`endif
        return v;
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        enable = 1'b0;
        tx_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Entered with the first sample after the PRE-entry edge; leaves on the IDLE sample.
    task automatic check_frame(input logic [7:0] data, input string name);
        int wave_err = 0;
        int busy_cycles = 0;
        int pulses = 0;
        for (int k = 0; k < 16 * BC; k++) begin
            if (antenna_en !== exp_chip(data, k)) wave_err++;
            if (busy === 1'b1) busy_cycles++;
            if (frame_done === 1'b1) pulses++;
            tick();
        end
        for (int g = 0; g < GC; g++) begin
            if (antenna_en !== 1'b0) wave_err++;
            if (busy === 1'b1) busy_cycles++;
            if (frame_done === 1'b1) pulses++;
            tick();
        end
        if (frame_done === 1'b1) pulses++;
        n_cmp++;
        if (wave_err !== 0) begin
            n_err++;
            $display("FAIL %s wave: %0d wrong cycles, required 0", name, wave_err);
        end
        n_cmp++;
        if (busy_cycles !== 72) begin
            n_err++;
            $display("FAIL %s busy_len: got %0d, required 72", name, busy_cycles);
        end
        n_cmp++;
        if (pulses !== 1 || frame_done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s frame_end: pulses=%0d fd=%b busy=%b, required 1/1/0",
                     name, pulses, frame_done, busy);
        end
    endtask

    task automatic test_reset();
        tick();
        n_cmp++;
        if ({tx_ready, antenna_en, busy, frame_done, overflow} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b, required 00000",
                     {tx_ready, antenna_en, busy, frame_done, overflow});
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: tx_ready=%b busy=%b, required 1/0", tx_ready, busy);
        end
    endtask

    task automatic test_single();
        enable = 1'b1;
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || antenna_en !== 1'b0) begin
            n_err++;
            $display("FAIL single_latency: busy=%b ant=%b at t+1, required 0/0", busy, antenna_en);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_start: busy=%b at t+2, required 1", busy);
        end
        check_frame(8'h3C, "single");
    endtask

    task automatic test_fifo_full();
        logic [7:0] bytes [5];
        int idle_busy = 0;
        bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3;
        bytes[3] = 8'hD4; bytes[4] = 8'hE5;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tx_data = bytes[i];
            tx_valid = 1'b1;
            tick();
            if (i == 2) begin
                n_cmp++;
                if (tx_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL full_ready3: got %b, required 1", tx_ready);
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (tx_ready !== 1'b0 || overflow !== 1'b0) begin
                    n_err++;
                    $display("FAIL full_ready4: ready=%b ovf=%b, required 0/0", tx_ready, overflow);
                end
            end
        end
        tx_valid = 1'b0;
        n_cmp++;
        if (overflow !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL full_overflow: ovf=%b busy=%b, required 1/0", overflow, busy);
        end
        tick();
        tick();
        enable = 1'b1;
        tick();
        check_frame(8'hA1, "full_f0");
        tick();
        check_frame(8'hB2, "full_f1");
        tick();
        check_frame(8'hC3, "full_f2");
        tick();
        check_frame(8'hD4, "full_f3");
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busy !== 1'b0) idle_busy++;
        end
        n_cmp++;
        if (idle_busy !== 0 || tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL full_drained: busy cycles=%0d ready=%b, required 0/1",
                     idle_busy, tx_ready);
        end
    endtask

    task automatic test_abort();
        int wave_err = 0;
        int gap_err = 0;
        int idle_busy = 0;
        do_reset();
        enable = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'hFF;
        tick();
        tx_data = 8'h11;
        tick();
        tx_valid = 1'b0;
        tick();
        // Sample k=49 falls in data bit 3.
        for (int k = 0; k <= 49; k++) begin
            if (antenna_en !== exp_chip(8'hFF, k)) wave_err++;
            if (k < 49) tick();
        end
        n_cmp++;
        if (wave_err !== 0) begin
            n_err++;
            $display("FAIL abort_prefix: %0d wrong cycles, required 0", wave_err);
        end
        enable = 1'b0;
        tick();
        n_cmp++;
        if (antenna_en !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL abort_edge: ant=%b busy=%b, required 0/1", antenna_en, busy);
        end
        for (int g = 1; g < GC; g++) begin
            tick();
            if (antenna_en !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0) gap_err++;
        end
        tick();
        n_cmp++;
        if (gap_err !== 0 || frame_done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_gap: gap errs=%0d fd=%b busy=%b, required 0/1/0",
                     gap_err, frame_done, busy);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy !== 1'b0 || antenna_en !== 1'b0) idle_busy++;
        end
        n_cmp++;
        if (idle_busy !== 0) begin
            n_err++;
            $display("FAIL abort_hold: active cycles=%0d, required 0", idle_busy);
        end
        enable = 1'b1;
        tick();
        check_frame(8'h11, "abort_next");
    endtask

    task automatic test_reset_mid();
        int idle_busy = 0;
        do_reset();
        enable = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'h3C;
        tick();
        tx_data = 8'h55;
        tick();
        tx_valid = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (antenna_en !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_pre: ant=%b busy=%b, required 1/1", antenna_en, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({antenna_en, busy, tx_ready} !== 3'b000) begin
            n_err++;
            $display("FAIL rmid_async: ant/busy/ready=%b, required 000",
                     {antenna_en, busy, tx_ready});
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_ready: got %b, required 1", tx_ready);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (busy !== 1'b0) idle_busy++;
        end
        n_cmp++;
        if (idle_busy !== 0) begin
            n_err++;
            $display("FAIL rmid_empty: busy cycles=%0d, required 0", idle_busy);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_data = 8'(8'h40 + i);
            tx_valid = 1'b1;
            tick();
        end
        tx_valid = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (tx_ready !== 1'b0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL pp_full: ready=%b ovf=%b, required 0/0", tx_ready, overflow);
        end
        enable = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'h99;
        tick();
        n_cmp++;
        if (overflow !== 1'b1 || busy !== 1'b1 || tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL pp_edge: ovf=%b busy=%b ready=%b, required 1/1/1",
                     overflow, busy, tx_ready);
        end
        tx_data = 8'h77;
        tick();
        tx_valid = 1'b0;
        n_cmp++;
        if (tx_ready !== 1'b0) begin
            n_err++;
            $display("FAIL pp_refill: ready=%b, required 0", tx_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fifo_full();
        test_abort();
        test_reset_mid();
        test_push_pop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
